// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the register file's single write port, with read-side
// forwarding of queued values. Optional same-cycle bypass: define REGFILE_WBQ_BYPASS_EN.
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [ADDR_W-1:0]        i_in_reg,
    input  logic [DATA_W-1:0]        i_in_data,
    input  logic                     i_wr_stall,
    output logic [ADDR_W-1:0]        o_DstReg,
    output logic [DATA_W-1:0]        o_DstData,
    output logic                     o_WriteReg,
    input  logic [ADDR_W-1:0]        i_SrcReg1,
    input  logic [ADDR_W-1:0]        i_SrcReg2,
    output logic                     o_fwd_hit1,
    output logic [DATA_W-1:0]        o_fwd_data1,
    output logic                     o_fwd_hit2,
    output logic [DATA_W-1:0]        o_fwd_data2,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_empty;
    logic              w_q_write;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_age_idx [DEPTH];

    assign w_empty    = (r_count == '0);
    assign o_in_ready = (r_count != CNT_W'(DEPTH));
    assign w_q_write  = !w_empty && !i_wr_stall;

`ifdef REGFILE_WBQ_BYPASS_EN
    assign w_bypass = w_empty && !i_wr_stall && i_in_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed request goes straight to the write port and never occupies an entry.
    assign w_push     = i_in_valid && o_in_ready && !w_bypass;
    assign w_pop      = w_q_write;
    assign o_WriteReg = w_q_write || w_bypass;
    assign o_count    = r_count;

    always_comb begin
        o_DstReg  = '0;
        o_DstData = '0;
        if (w_bypass) begin
            o_DstReg  = i_in_reg;
            o_DstData = i_in_data;
        end else if (!w_empty) begin
            o_DstReg  = r_reg[r_rd_ptr];
            o_DstData = r_data[r_rd_ptr];
        end
    end

    // w_age_idx[k] is the k-th oldest slot; pointer arithmetic wraps since DEPTH is a power of two.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign w_age_idx[g] = r_rd_ptr + PTR_W'(g);
    end

    always_comb begin
        o_fwd_hit1  = 1'b0;
        o_fwd_data1 = '0;
        o_fwd_hit2  = 1'b0;
        o_fwd_data2 = '0;
        // Walk oldest to youngest so the last match left standing is the youngest.
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < r_count) begin
                if (r_reg[w_age_idx[k]] == i_SrcReg1) begin
                    o_fwd_hit1  = 1'b1;
                    o_fwd_data1 = r_data[w_age_idx[k]];
                end
                if (r_reg[w_age_idx[k]] == i_SrcReg2) begin
                    o_fwd_hit2  = 1'b1;
                    o_fwd_data2 = r_data[w_age_idx[k]];
                end
            end
        end
        if (w_bypass && (i_in_reg == i_SrcReg1)) begin
            o_fwd_hit1  = 1'b1;
            o_fwd_data1 = i_in_data;
        end
        if (w_bypass && (i_in_reg == i_SrcReg2)) begin
            o_fwd_hit2  = 1'b1;
            o_fwd_data2 = i_in_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_reg[r_wr_ptr]  <= i_in_reg;
            r_data[r_wr_ptr] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue; covers the bypass build when REGFILE_WBQ_BYPASS_EN is defined.
module tb_regfile_wb_queue;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [3:0]  i_in_reg = '0;
    logic [15:0] i_in_data = '0;
    logic        i_wr_stall = 1'b0;
    logic [3:0]  o_DstReg;
    logic [15:0] o_DstData;
    logic        o_WriteReg;
    logic [3:0]  i_SrcReg1 = '0;
    logic [3:0]  i_SrcReg2 = '0;
    logic        o_fwd_hit1;
    logic [15:0] o_fwd_data1;
    logic        o_fwd_hit2;
    logic [15:0] o_fwd_data2;
    logic [2:0]  o_count;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_queue #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_reg(i_in_reg), .i_in_data(i_in_data), .i_wr_stall(i_wr_stall),
        .o_DstReg(o_DstReg), .o_DstData(o_DstData), .o_WriteReg(o_WriteReg),
        .i_SrcReg1(i_SrcReg1), .i_SrcReg2(i_SrcReg2),
        .o_fwd_hit1(o_fwd_hit1), .o_fwd_data1(o_fwd_data1),
        .o_fwd_hit2(o_fwd_hit2), .o_fwd_data2(o_fwd_data2),
        .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [15:0] d);
        i_in_valid = 1'b1;
        i_in_reg   = r;
        i_in_data  = d;
        cyc();
        i_in_valid = 1'b0;
    endtask

    initial begin
        // 1: reset with a stale push request present
        i_rst = 1'b1; i_in_valid = 1'b1; i_in_reg = 4'd9; i_in_data = 16'hDEAD;
        i_SrcReg1 = 4'd9; i_SrcReg2 = 4'd0;
        cyc(); cyc();
        i_rst = 1'b0; i_in_valid = 1'b0;
        #1;
        check_val("rst_count", 32'(o_count), 32'd0);
        check_val("rst_wr", 32'(o_WriteReg), 32'd0);
        check_val("rst_ready", 32'(o_in_ready), 32'd1);
        check_val("rst_hit1", 32'(o_fwd_hit1), 32'd0);
        check_val("rst_hit2", 32'(o_fwd_hit2), 32'd0);
        check_val("rst_dst", {o_DstReg, o_DstData}, 32'd0);

        // 2: single push, one-cycle latency (zero with bypass)
        i_in_valid = 1'b1; i_in_reg = 4'd3; i_in_data = 16'h1234; i_SrcReg1 = 4'd3;
        #1;
`ifdef REGFILE_WBQ_BYPASS_EN
        check_val("t2_byp_wr", 32'(o_WriteReg), 32'd1);
        check_val("t2_byp_dst", {o_DstReg, o_DstData}, {16'd3, 16'h1234});
        check_val("t2_byp_hit", {o_fwd_hit1, o_fwd_data1}, {1'b1, 16'h1234});
        cyc();
        i_in_valid = 1'b0;
        #1;
        check_val("t2_byp_count", 32'(o_count), 32'd0);
        check_val("t2_byp_idle", 32'(o_WriteReg), 32'd0);
`else
        check_val("t2_pre_wr", 32'(o_WriteReg), 32'd0);
        check_val("t2_pre_hit", 32'(o_fwd_hit1), 32'd0);
        cyc();
        i_in_valid = 1'b0;
        #1;
        check_val("t2_wr", 32'(o_WriteReg), 32'd1);
        check_val("t2_dst", {o_DstReg, o_DstData}, {16'd3, 16'h1234});
        check_val("t2_count1", 32'(o_count), 32'd1);
        check_val("t2_fwd_head", {o_fwd_hit1, o_fwd_data1}, {1'b1, 16'h1234});
        cyc();
        check_val("t2_count0", 32'(o_count), 32'd0);
        check_val("t2_idle", 32'(o_WriteReg), 32'd0);
        check_val("t2_dst0", {o_DstReg, o_DstData}, 32'd0);
`endif

        // 3: fill while stalled, fifth push dropped, then drain in order
        i_wr_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_in_valid = 1'b1;
            i_in_reg   = 4'(i + 1);
            i_in_data  = 16'hA001 + 16'(i);
            #1;
            check_val($sformatf("t3_ready%0d", i), 32'(o_in_ready), (i < 4) ? 32'd1 : 32'd0);
            check_val($sformatf("t3_stall_wr%0d", i), 32'(o_WriteReg), 32'd0);
            cyc();
        end
        i_in_valid = 1'b0;
        i_SrcReg1 = 4'd3; i_SrcReg2 = 4'd5;
        #1;
        check_val("t3_full", 32'(o_count), 32'd4);
        check_val("t3_fwd_r3", {o_fwd_hit1, o_fwd_data1}, {1'b1, 16'hA003});
        check_val("t3_fwd_r5", {o_fwd_hit2, o_fwd_data2}, 32'd0);
        check_val("t3_stall_head", {o_DstReg, o_DstData}, {16'd1, 16'hA001});
        i_wr_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("t3_drain_wr%0d", i), 32'(o_WriteReg), 32'd1);
            check_val($sformatf("t3_drain_dst%0d", i), {o_DstReg, o_DstData},
                      {12'd0, 4'(i + 1), 16'hA001 + 16'(i)});
            cyc();
        end
        check_val("t3_done_wr", 32'(o_WriteReg), 32'd0);
        check_val("t3_done_count", 32'(o_count), 32'd0);

        // 4: youngest-match forwarding
        i_wr_stall = 1'b1;
        push(4'd5, 16'h1111);
        push(4'd5, 16'h2222);
        i_SrcReg1 = 4'd5; i_SrcReg2 = 4'd6;
        #1;
        check_val("t4_count", 32'(o_count), 32'd2);
        check_val("t4_fwd1", {o_fwd_hit1, o_fwd_data1}, {1'b1, 16'h2222});
        check_val("t4_fwd2", {o_fwd_hit2, o_fwd_data2}, 32'd0);

        // 5: steady push+pop at count 2, pointers wrap, register 0 is ordinary
        i_wr_stall = 1'b0;
        i_SrcReg2  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            i_in_valid = 1'b1;
            i_in_reg   = 4'(i);
            i_in_data  = 16'hC000 + 16'(i);
            #1;
            check_val($sformatf("t5_count%0d", i), 32'(o_count), 32'd2);
            check_val($sformatf("t5_wr%0d", i), 32'(o_WriteReg), 32'd1);
            check_val($sformatf("t5_data%0d", i), 32'(o_DstData),
                      (i == 0) ? 32'h1111 : (i == 1) ? 32'h2222 : 32'(16'hC000 + 16'(i - 2)));
            if (i == 1)
                check_val("t5_fwd_r0", {o_fwd_hit2, o_fwd_data2}, {1'b1, 16'hC000});
            cyc();
        end
        i_in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_val($sformatf("t5_tail%0d", i), {o_DstReg, o_DstData},
                      {12'd0, 4'(6 + i), 16'hC006 + 16'(i)});
            cyc();
        end
        check_val("t5_empty", 32'(o_count), 32'd0);

        // 6: reset mid-drain discards queued entries
        i_wr_stall = 1'b1;
        push(4'd2, 16'h0B01);
        push(4'd3, 16'h0B02);
        push(4'd4, 16'h0B03);
        i_wr_stall = 1'b0;
        i_SrcReg1 = 4'd3;
        #1;
        check_val("t6_first", {o_DstReg, o_DstData}, {16'd2, 16'h0B01});
        cyc();
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("t6_count%0d", i), 32'(o_count), 32'd0);
            check_val($sformatf("t6_wr%0d", i), 32'(o_WriteReg), 32'd0);
            check_val($sformatf("t6_dst%0d", i), {o_DstReg, o_DstData}, 32'd0);
            check_val($sformatf("t6_hit%0d", i), 32'(o_fwd_hit1), 32'd0);
            cyc();
        end
        check_val("t6_ready", 32'(o_in_ready), 32'd1);

`ifdef REGFILE_WBQ_BYPASS_EN
        i_in_valid = 1'b1; i_in_reg = 4'd7; i_in_data = 16'hBEEF; i_SrcReg2 = 4'd7;
        #1;
        check_val("byp_wr", 32'(o_WriteReg), 32'd1);
        check_val("byp_dst", {o_DstReg, o_DstData}, {16'd7, 16'hBEEF});
        check_val("byp_fwd", {o_fwd_hit2, o_fwd_data2}, {1'b1, 16'hBEEF});
        cyc();
        i_in_valid = 1'b0;
        #1;
        check_val("byp_count", 32'(o_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
